// File: rtl/instruction_mem.sv
// instruction_mem: free-running program counter addressing a fixed instruction ROM.
// Ports:
//   clk             - single clock, all state updates on its rising edge
//   reset           - synchronous active-high reset, forces counter to 0
//   counter         - current program-counter value (ADDR_WIDTH bits)
//   Instruction_out - ROM word addressed by counter, combinational (DATA_WIDTH bits)

module up_counter #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] counter
);
    logic [ADDR_WIDTH-1:0] counter_q, counter_d;

    // Natural overflow of the adder gives the modulo-2^ADDR_WIDTH wrap.
    always_comb counter_d = reset ? '0 : counter_q + ADDR_WIDTH'(1);

    always_ff @(posedge clk) counter_q <= counter_d;

    assign counter = counter_q;
endmodule

module Instruction_Mem #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    output logic [DATA_WIDTH-1:0] Instruction_out,
    input  logic [ADDR_WIDTH-1:0] address
);
    // Only the first eight words hold program; every other address reads zero.
    always_comb begin
        Instruction_out = '0;
        case (32'(address))
            0:       Instruction_out = DATA_WIDTH'(32'h1001_0005);
            1:       Instruction_out = DATA_WIDTH'(32'h1002_000A);
            2:       Instruction_out = DATA_WIDTH'(32'h2003_0102);
            3:       Instruction_out = DATA_WIDTH'(32'h3004_0301);
            4:       Instruction_out = DATA_WIDTH'(32'h4005_0403);
            5:       Instruction_out = DATA_WIDTH'(32'h5000_0005);
            6:       Instruction_out = DATA_WIDTH'(32'h6000_0000);
            7:       Instruction_out = DATA_WIDTH'(32'hF000_0000);
            default: Instruction_out = '0;
        endcase
    end
endmodule

module instruction_mem #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [ADDR_WIDTH-1:0] counter,
    output logic [DATA_WIDTH-1:0] Instruction_out
);
    up_counter #(.ADDR_WIDTH(ADDR_WIDTH)) u_counter (
        .clk     (clk),
        .reset   (reset),
        .counter (counter)
    );

    Instruction_Mem #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_rom (
        .Instruction_out (Instruction_out),
        .address         (counter)
    );
endmodule

// File: tb/tb_instruction_mem.sv
// tb_instruction_mem: directed and randomized checks of instruction_mem against a reference model.

module tb_instruction_mem;
    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  counter;
    logic [31:0] Instruction_out;

    int compared = 0;
    int mismatched = 0;
    int exp_pc = 0;

    logic [31:0] prog [8] = '{32'h1001_0005, 32'h1002_000A, 32'h2003_0102, 32'h3004_0301,
                              32'h4005_0403, 32'h5000_0005, 32'h6000_0000, 32'hF000_0000};

    instruction_mem dut (
        .clk             (clk),
        .reset           (reset),
        .counter         (counter),
        .Instruction_out (Instruction_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_rom(input int a);
        return (a < 8) ? prog[a] : 32'h0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, update the model from the reset level seen at that edge,
    // then compare both outputs 1 ns later.
    task automatic step();
        @(posedge clk);
        exp_pc = reset ? 0 : (exp_pc + 1) % DEPTH;
        #1;
        check("pc", 32'(counter), 32'(exp_pc));
        check("instr", Instruction_out, ref_rom(exp_pc));
    endtask

    initial begin
        step();
        step();
        check("reset_pc", 32'(counter), 32'd0);
        check("reset_instr", Instruction_out, 32'h1001_0005);
        #4 reset = 1'b0;
        step();
        check("first_pc", 32'(counter), 32'd1);
        check("first_instr", Instruction_out, 32'h1002_000A);
        for (int i = 2; i <= 63; i++) begin
            step();
            if (i == 8) check("pc8_instr", Instruction_out, 32'h0);
        end
        check("pc63", 32'(counter), 32'd63);
        check("pc63_instr", Instruction_out, 32'h0);
        step();
        check("wrap_pc", 32'(counter), 32'd0);
        check("wrap_instr", Instruction_out, 32'h1001_0005);
        for (int i = 1; i <= 37; i++) step();
        check("pc37", 32'(counter), 32'd37);
        reset = 1'b1;
        step();
        check("midreset_pc", 32'(counter), 32'd0);
        reset = 1'b0;
        step();
        check("resume_pc", 32'(counter), 32'd1);
        #2 reset = 1'b1;
        #3 reset = 1'b0;
        check("glitch_hold_pc", 32'(counter), 32'd1);
        step();
        check("glitch_pc", 32'(counter), 32'd2);
        for (int i = 0; i < 200; i++) begin
            reset = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
